// File: rtl/tdc_hit_stamper.sv
// tdc_hit_stamper: timestamps rising edges on NCH hit lines as {epoch, chan, coarse}
// and buffers the words in a first-word-fall-through FIFO with valid/ready readout.
// The epoch counter extends the 16-bit coarse count and advances once per carry rise.
// Optional build macro TDC_HIT_SYNC_EN inserts a 2-flop synchronizer on every hit line.
module tdc_hit_stamper #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned EPOCH_W = 12,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DROP_W  = 8
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic [15:0]                     coarse,
  input  logic                            coarse_cy,
  input  logic [NCH-1:0]                  hit,
  output logic [EPOCH_W+$clog2(NCH)+15:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(DEPTH):0]          fifo_cnt,
  output logic [DROP_W-1:0]               drop_cnt
);

  localparam int unsigned CW   = $clog2(NCH);
  localparam int unsigned TW   = EPOCH_W + CW + 16;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned SW   = DROP_W + CW + 1;

  logic [NCH-1:0]     hit_s;
  logic [NCH-1:0]     hit_d_q;
  logic               cy_d_q;
  logic [EPOCH_W-1:0] epoch_q;
  logic [NCH-1:0]     pend_q, pend_d;
  logic [TW-1:0]      pend_ts_q [NCH];
  logic [TW-1:0]      pend_ts_d [NCH];
  logic [TW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic [NCH-1:0]     edge_w;
  logic               epoch_inc;
  logic               pop, push, push_ok, found;
  logic [CW-1:0]      sel;
  logic [CW:0]        ndrop;
  logic [SW-1:0]      drop_sum;

`ifdef TDC_HIT_SYNC_EN
  logic [NCH-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer per hit line, cleared with the rest of the block
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hit;
      sync2_q <= sync1_q;
    end
  end

  assign hit_s = sync2_q;
`else
  assign hit_s = hit;
`endif

  // Edge detection, writer arbitration, pending-capture and drop accounting
  always_comb begin
    edge_w    = hit_s & ~hit_d_q;
    epoch_inc = coarse_cy & ~cy_d_q;
    out_valid = (cnt_q != '0);
    pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO
    // being drained still accepts the next pending word.
    push_ok   = (cnt_q < CNTW'(DEPTH)) | pop;

    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pend_q[i] && !found) begin
        sel   = CW'(i);
        found = 1'b1;
      end
    end
    push = found & push_ok;

    pend_d    = pend_q;
    pend_ts_d = pend_ts_q;
    ndrop     = '0;
    if (push) pend_d[sel] = 1'b0;
    // Checking against pend_d (after the push clear) lets a fresh capture win
    // over the word leaving the same slot.
    for (int unsigned i = 0; i < NCH; i++) begin
      if (edge_w[i]) begin
        if (pend_d[i]) begin
          ndrop = ndrop + (CW+1)'(1);
        end else begin
          pend_d[i]    = 1'b1;
          pend_ts_d[i] = {epoch_q, CW'(i), coarse};
        end
      end
    end

    drop_sum = SW'(drop_q) + SW'(ndrop);
    drop_d   = (drop_sum > SW'({DROP_W{1'b1}})) ? '1 : drop_sum[DROP_W-1:0];
    cnt_d    = cnt_q + CNTW'(push) - CNTW'(pop);
  end

  // Control state: edge/carry history, epoch, pending flags, FIFO pointers, counters
  always_ff @(posedge clk) begin
    if (clr) begin
      hit_d_q <= hit_s;
      cy_d_q  <= coarse_cy;
      epoch_q <= '0;
      pend_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      drop_q  <= '0;
    end else begin
      hit_d_q <= hit_s;
      cy_d_q  <= coarse_cy;
      if (epoch_inc) epoch_q <= epoch_q + 1'b1;
      pend_q  <= pend_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // Data storage: pending timestamps and FIFO array, qualified by the flags above
  always_ff @(posedge clk) begin
    pend_ts_q <= pend_ts_d;
    if (push && !clr) mem_q[wptr_q] <= pend_ts_q[sel];
  end

  assign out_data = out_valid ? mem_q[rptr_q] : '0;
  assign fifo_cnt = cnt_q;
  assign drop_cnt = drop_q;

endmodule
